// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester handshake and memory strobe bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          we0;
    logic          we1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          MAR_load;
    logic          Bc;
    logic          Ac;
    logic          CS;
    logic          OE;
    logic          WE;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        output ack0, ack1, rdata, busy, mem_addr, mem_wdata,
        output MAR_load, Bc, Ac, CS, OE, WE
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        input  ack0, ack1, rdata, busy, mem_addr, mem_wdata,
        input  MAR_load, Bc, Ac, CS, OE, WE
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-requester round-robin arbiter sequencing strobed memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int STRB_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_sel  = 3'd2;
    localparam logic [2:0] c_st_strb = 3'd3;
    localparam logic [2:0] c_st_rels = 3'd4;

    localparam logic [3:0] c_strb_last = 4'(STRB_CYCLES - 1);

    logic [2:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_last_gnt;
    logic          r_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_mar_load;
    logic          r_bc;
    logic          r_ac;
    logic          r_cs_n;
    logic          r_oe_n;
    logic          r_we_n;

    logic          w_any_req;
    logic          w_winner;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the requester not served last time wins; a lone request always wins.
    assign w_winner  = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_last_gnt  <= 1'b1;
            r_wr        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_mar_load  <= 1'b0;
            r_bc        <= 1'b0;
            r_ac        <= 1'b0;
            r_cs_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_last_gnt  <= w_winner;
                        r_mem_addr  <= w_winner ? bus.addr1  : bus.addr0;
                        r_mem_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
                        r_wr        <= w_winner ? bus.we1    : bus.we0;
                        r_mar_load  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_mar_load <= 1'b0;
                    r_cs_n     <= 1'b0;
                    r_bc       <= ~r_wr;
                    r_ac       <= r_wr;
                    r_state    <= c_st_sel;
                end
                c_st_sel: begin
                    r_oe_n  <= r_wr;
                    r_we_n  <= ~r_wr;
                    r_cnt   <= c_strb_last;
                    r_state <= c_st_strb;
                end
                c_st_strb: begin
                    if (r_cnt == 4'd0) begin
                        r_oe_n <= 1'b1;
                        r_we_n <= 1'b1;
                        r_bc   <= 1'b0;
                        r_ac   <= 1'b0;
                        if (!r_wr) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        r_ack0  <= ~r_last_gnt;
                        r_ack1  <= r_last_gnt;
                        r_state <= c_st_rels;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_rels: begin
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_mar_load <= 1'b0;
                    r_bc       <= 1'b0;
                    r_ac       <= 1'b0;
                    r_cs_n     <= 1'b1;
                    r_oe_n     <= 1'b1;
                    r_we_n     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.MAR_load  = r_mar_load;
    assign bus.Bc        = r_bc;
    assign bus.Ac        = r_ac;
    assign bus.CS        = r_cs_n;
    assign bus.OE        = r_oe_n;
    assign bus.WE        = r_we_n;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench; one DUT with 1-cycle strobe, one with 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1, mem_rdata;

    int checks = 0;
    int errors = 0;

    // Per-window tallies filled by observe()
    int n_mar, n_cs, n_oe, n_we, n_bc, n_ac, n_busy, n_bad, n_ack0, n_ack1, n_ack;
    int k_ack0, k_ack1;
    int ack_who [8];
    int ack_k   [8];

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus1 ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) bus3 ();

    mem_port_arbiter #(.AW(8), .DW(8), .STRB_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .STRB_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    assign bus1.req0 = req0;   assign bus3.req0 = req0;
    assign bus1.req1 = req1;   assign bus3.req1 = req1;
    assign bus1.addr0 = addr0; assign bus3.addr0 = addr0;
    assign bus1.addr1 = addr1; assign bus3.addr1 = addr1;
    assign bus1.wdata0 = wdata0; assign bus3.wdata0 = wdata0;
    assign bus1.wdata1 = wdata1; assign bus3.wdata1 = wdata1;
    assign bus1.we0 = we0;     assign bus3.we0 = we0;
    assign bus1.we1 = we1;     assign bus3.we1 = we1;
    assign bus1.mem_rdata = mem_rdata; assign bus3.mem_rdata = mem_rdata;

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Samples ncyc negedges of the selected DUT and tallies strobe activity.
    task automatic observe(input bit sel3, input int ncyc, input bit drop);
        logic mar, cs, oe, we, bc, ac, bsy, a0, a1;
        n_mar = 0; n_cs = 0; n_oe = 0; n_we = 0; n_bc = 0; n_ac = 0;
        n_busy = 0; n_bad = 0; n_ack0 = 0; n_ack1 = 0; n_ack = 0;
        k_ack0 = 0; k_ack1 = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            mar = sel3 ? bus3.MAR_load : bus1.MAR_load;
            cs  = sel3 ? bus3.CS   : bus1.CS;
            oe  = sel3 ? bus3.OE   : bus1.OE;
            we  = sel3 ? bus3.WE   : bus1.WE;
            bc  = sel3 ? bus3.Bc   : bus1.Bc;
            ac  = sel3 ? bus3.Ac   : bus1.Ac;
            bsy = sel3 ? bus3.busy : bus1.busy;
            a0  = sel3 ? bus3.ack0 : bus1.ack0;
            a1  = sel3 ? bus3.ack1 : bus1.ack1;
            if (mar) n_mar++;
            if (!cs) n_cs++;
            if (!oe) n_oe++;
            if (!we) n_we++;
            if (bc)  n_bc++;
            if (ac)  n_ac++;
            if (bsy) n_busy++;
            if (!oe && !we) n_bad++;
            if ((!oe || !we) && cs) n_bad++;
            if (a0) begin
                n_ack0++;
                if (k_ack0 == 0) k_ack0 = k;
                if (n_ack < 8) begin ack_who[n_ack] = 0; ack_k[n_ack] = k; end
                n_ack++;
                if (drop) req0 = 1'b0;
            end
            if (a1) begin
                n_ack1++;
                if (k_ack1 == 0) k_ack1 = k;
                if (n_ack < 8) begin ack_who[n_ack] = 1; ack_k[n_ack] = k; end
                n_ack++;
                if (drop) req1 = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h99;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
        checks++; if ({bus1.CS, bus1.OE, bus1.WE} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b expected 111", {bus1.CS, bus1.OE, bus1.WE}); end
        checks++; if ({bus1.MAR_load, bus1.Bc, bus1.Ac, bus1.ack0, bus1.ack1} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {bus1.MAR_load, bus1.Bc, bus1.Ac, bus1.ack0, bus1.ack1}); end
        checks++; if ({bus1.rdata, bus1.mem_addr, bus1.mem_wdata} !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", {bus1.rdata, bus1.mem_addr, bus1.mem_wdata}); end
        checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b expected 0", bus3.busy); end
        req0 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h1A; mem_rdata = 8'h5C;
        observe(1'b0, 6, 1'b1);
        checks++; if (n_mar !== 1) begin errors++; $display("FAIL rd_mar_cycles: got %0d expected 1", n_mar); end
        checks++; if (n_cs !== 3) begin errors++; $display("FAIL rd_cs_cycles: got %0d expected 3", n_cs); end
        checks++; if (n_oe !== 1 || n_we !== 0) begin errors++; $display("FAIL rd_oe_we: got oe=%0d we=%0d expected oe=1 we=0", n_oe, n_we); end
        checks++; if (n_bc !== 2 || n_ac !== 0) begin errors++; $display("FAIL rd_bc_ac: got bc=%0d ac=%0d expected bc=2 ac=0", n_bc, n_ac); end
        checks++; if (n_ack0 !== 1 || k_ack0 !== 4 || n_ack1 !== 0) begin errors++; $display("FAIL rd_ack: got n=%0d at=%0d n1=%0d expected n=1 at=4 n1=0", n_ack0, k_ack0, n_ack1); end
        checks++; if (n_busy !== 4) begin errors++; $display("FAIL rd_busy: got %0d expected 4", n_busy); end
        checks++; if (bus1.rdata !== 8'h5C) begin errors++; $display("FAIL rd_rdata: got %h expected 5c", bus1.rdata); end
        checks++; if (bus1.mem_addr !== 8'h1A) begin errors++; $display("FAIL rd_addr: got %h expected 1a", bus1.mem_addr); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL rd_strobe_rules: got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_single_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h07; wdata1 = 8'hA5; mem_rdata = 8'h33;
        observe(1'b0, 6, 1'b1);
        checks++; if (bus1.mem_addr !== 8'h07 || bus1.mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_bus: got addr=%h data=%h expected 07/a5", bus1.mem_addr, bus1.mem_wdata); end
        checks++; if (n_ac !== 2 || n_bc !== 0) begin errors++; $display("FAIL wr_ac_bc: got ac=%0d bc=%0d expected ac=2 bc=0", n_ac, n_bc); end
        checks++; if (n_we !== 1 || n_oe !== 0) begin errors++; $display("FAIL wr_we_oe: got we=%0d oe=%0d expected we=1 oe=0", n_we, n_oe); end
        checks++; if (n_ack1 !== 1 || k_ack1 !== 4 || n_ack0 !== 0) begin errors++; $display("FAIL wr_ack: got n=%0d at=%0d n0=%0d expected n=1 at=4 n0=0", n_ack1, k_ack1, n_ack0); end
        checks++; if (bus1.rdata !== 8'h5C) begin errors++; $display("FAIL wr_rdata_kept: got %h expected 5c", bus1.rdata); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL wr_strobe_rules: got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_contention();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h77;
        mem_rdata = 8'h99;
        do_reset();
        observe(1'b0, 20, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (n_ack !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d expected 4", n_ack); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_who[i] !== (i % 2) || ack_k[i] !== 4 + 5 * i) begin
                errors++;
                $display("FAIL rr_grant%0d: got who=%0d at=%0d expected who=%0d at=%0d", i, ack_who[i], ack_k[i], i % 2, 4 + 5 * i);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL rr_strobe_rules: got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_stretch();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C; mem_rdata = 8'hC3;
        observe(1'b1, 9, 1'b1);
        checks++; if (n_oe !== 3 || n_we !== 0) begin errors++; $display("FAIL st_oe: got oe=%0d we=%0d expected oe=3 we=0", n_oe, n_we); end
        checks++; if (n_cs !== 5) begin errors++; $display("FAIL st_cs: got %0d expected 5", n_cs); end
        checks++; if (n_ack0 !== 1 || k_ack0 !== 6) begin errors++; $display("FAIL st_ack: got n=%0d at=%0d expected n=1 at=6", n_ack0, k_ack0); end
        checks++; if (bus3.rdata !== 8'hC3) begin errors++; $display("FAIL st_rdata: got %h expected c3", bus3.rdata); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL st_strobe_rules: got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_reset_mid_write();
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h55; wdata1 = 8'h0F;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++; if (bus1.WE !== 1'b0) begin errors++; $display("FAIL rm_in_strb: got WE=%b expected 0", bus1.WE); end
        reset = 1'b1; req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({bus1.WE, bus1.CS, bus1.busy, bus1.ack1} !== 4'b1100) begin errors++; $display("FAIL rm_abandon: got WE,CS,busy,ack1=%b expected 1100", {bus1.WE, bus1.CS, bus1.busy, bus1.ack1}); end
        observe(1'b0, 4, 1'b0);
        checks++; if (n_ack !== 0 || n_cs !== 0) begin errors++; $display("FAIL rm_quiet: got acks=%0d cs=%0d expected 0/0", n_ack, n_cs); end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h42;
        observe(1'b0, 6, 1'b1);
        checks++; if (n_ack0 !== 1 || k_ack0 !== 4 || bus1.mem_addr !== 8'h42) begin errors++; $display("FAIL rm_resume: got n=%0d at=%0d addr=%h expected 1/4/42", n_ack0, k_ack0, bus1.mem_addr); end
    endtask

    task automatic test_drop_in_sel();
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h11; wdata0 = 8'h22;
        @(negedge clk); @(negedge clk);
        checks++; if (bus1.CS !== 1'b0 || bus1.Ac !== 1'b1) begin errors++; $display("FAIL dr_in_sel: got CS=%b Ac=%b expected 0/1", bus1.CS, bus1.Ac); end
        req0 = 1'b0;
        observe(1'b0, 8, 1'b0);
        checks++; if (n_ack0 !== 1 || k_ack0 !== 2) begin errors++; $display("FAIL dr_ack: got n=%0d at=%0d expected 1/2", n_ack0, k_ack0); end
        checks++; if (n_mar !== 0 || n_busy !== 2 || n_cs !== 2) begin errors++; $display("FAIL dr_no_second: got mar=%0d busy=%0d cs=%0d expected 0/2/2", n_mar, n_busy, n_cs); end
        checks++; if (n_we !== 1 || bus1.busy !== 1'b0) begin errors++; $display("FAIL dr_done: got we=%0d busy=%b expected 1/0", n_we, bus1.busy); end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_stretch();
        test_reset_mid_write();
        test_drop_in_sel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
